// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store data.
// One transaction in flight; data has priority, bounded by a streak limit, with a request timeout.
module mem_port_arbiter #(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          MAX_D_STREAK = 4,
    parameter int          TIMEOUT      = 64,
    parameter logic [3:0]  FETCH_CTRL   = 4'h0
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFetchReq,
    input  logic [ADDR_W-1:0] iFetchAddr,
    output logic              oFetchDone,
    output logic              oFetchErr,
    output logic [DATA_W-1:0] oFetchInstr,
    input  logic              iDataReq,
    input  logic              iDataWe,
    input  logic [ADDR_W-1:0] iDataAddr,
    input  logic [DATA_W-1:0] iDataWData,
    input  logic [3:0]        iDataMemCtrl,
    output logic              oDataDone,
    output logic              oDataErr,
    output logic [DATA_W-1:0] oDataRData,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic [3:0]        oMemCtrl,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRData
);

    localparam int TIMER_W  = $clog2(TIMEOUT + 1);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [STREAK_W-1:0] streak_q,      streak_d;
    logic [TIMER_W-1:0]  timer_q,       timer_d;
    logic                owner_d_q,     owner_d_d;
    logic                mem_req_q,     mem_req_d;
    logic                mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,   mem_wdata_d;
    logic [3:0]          mem_ctrl_q,    mem_ctrl_d;
    logic                fetch_done_q,  fetch_done_d;
    logic                fetch_err_q,   fetch_err_d;
    logic [DATA_W-1:0]   fetch_instr_q, fetch_instr_d;
    logic                data_done_q,   data_done_d;
    logic                data_err_q,    data_err_d;
    logic [DATA_W-1:0]   data_rdata_q,  data_rdata_d;

    logic streak_full;
    logic grant_data;
    logic finish;
    logic finish_err;

    assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));
    assign grant_data  = iDataReq && !(iFetchReq && streak_full);
    assign finish      = iMemAck || (timer_q == TIMER_W'(TIMEOUT));
    assign finish_err  = !iMemAck;

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        timer_d       = timer_q;
        owner_d_d     = owner_d_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_ctrl_d    = mem_ctrl_q;
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        fetch_instr_d = fetch_instr_q;
        data_done_d   = 1'b0;
        data_err_d    = 1'b0;
        data_rdata_d  = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = BUSY;
                    owner_d_d   = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = iDataWe;
                    mem_addr_d  = iDataAddr;
                    mem_wdata_d = iDataWData;
                    mem_ctrl_d  = iDataMemCtrl;
                    timer_d     = TIMER_W'(1);
                    // grant_data with fetch pending implies the streak is not yet full
                    if (iFetchReq) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (iFetchReq) begin
                    state_d     = BUSY;
                    owner_d_d   = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = iFetchAddr;
                    mem_wdata_d = '0;
                    mem_ctrl_d  = FETCH_CTRL;
                    timer_d     = TIMER_W'(1);
                    streak_d    = '0;
                end
            end
            BUSY: begin
                if (finish) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner_d_q) begin
                        data_done_d = 1'b1;
                        data_err_d  = finish_err;
                        if (iMemAck && !mem_we_q) begin
                            data_rdata_d = iMemRData;
                        end
                    end else begin
                        fetch_done_d = 1'b1;
                        fetch_err_d  = finish_err;
                        if (iMemAck) begin
                            fetch_instr_d = iMemRData;
                        end
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q       <= IDLE;
            streak_q      <= '0;
            timer_q       <= '0;
            owner_d_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_ctrl_q    <= '0;
            fetch_done_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_instr_q <= '0;
            data_done_q   <= 1'b0;
            data_err_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            timer_q       <= timer_d;
            owner_d_q     <= owner_d_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_ctrl_q    <= mem_ctrl_d;
            fetch_done_q  <= fetch_done_d;
            fetch_err_q   <= fetch_err_d;
            fetch_instr_q <= fetch_instr_d;
            data_done_q   <= data_done_d;
            data_err_q    <= data_err_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign oFetchDone  = fetch_done_q;
    assign oFetchErr   = fetch_err_q;
    assign oFetchInstr = fetch_instr_q;
    assign oDataDone   = data_done_q;
    assign oDataErr    = data_err_q;
    assign oDataRData  = data_rdata_q;
    assign oMemReq     = mem_req_q;
    assign oMemWe      = mem_we_q;
    assign oMemAddr    = mem_addr_q;
    assign oMemWData   = mem_wdata_q;
    assign oMemCtrl    = mem_ctrl_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        iClk;
    logic        iRst;
    logic        iFetchReq;
    logic [31:0] iFetchAddr;
    logic        oFetchDone;
    logic        oFetchErr;
    logic [31:0] oFetchInstr;
    logic        iDataReq;
    logic        iDataWe;
    logic [31:0] iDataAddr;
    logic [31:0] iDataWData;
    logic [3:0]  iDataMemCtrl;
    logic        oDataDone;
    logic        oDataErr;
    logic [31:0] oDataRData;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemCtrl;
    logic        iMemAck;
    logic [31:0] iMemRData;

    int testsRun;
    int testsFailed;
    logic [31:0] expInstr;
    logic [31:0] expRData;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8), .FETCH_CTRL(4'h0)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr),
        .oFetchDone(oFetchDone), .oFetchErr(oFetchErr), .oFetchInstr(oFetchInstr),
        .iDataReq(iDataReq), .iDataWe(iDataWe), .iDataAddr(iDataAddr),
        .iDataWData(iDataWData), .iDataMemCtrl(iDataMemCtrl),
        .oDataDone(oDataDone), .oDataErr(oDataErr), .oDataRData(oDataRData),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemCtrl(oMemCtrl),
        .iMemAck(iMemAck), .iMemRData(iMemRData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                                 input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWData, input logic [3:0] dCtrl);
        iFetchReq    = fReq;
        iFetchAddr   = fAddr;
        iDataReq     = dReq;
        iDataWe      = dWe;
        iDataAddr    = dAddr;
        iDataWData   = dWData;
        iDataMemCtrl = dCtrl;
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        int n;
        logic isD;
        testsRun    = 0;
        testsFailed = 0;
        iRst        = 1'b1;
        iMemAck     = 1'b0;
        iMemRData   = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);

        // Reset state, observed before any clock edge
        #2;
        checkOutput("rst_memreq", {31'd0, oMemReq}, 32'd0);
        checkOutput("rst_fdone", {31'd0, oFetchDone}, 32'd0);
        checkOutput("rst_ddone", {31'd0, oDataDone}, 32'd0);
        checkOutput("rst_addr", oMemAddr, 32'd0);
        checkOutput("rst_instr", oFetchInstr, 32'd0);
        tick;
        tick;
        iRst = 1'b0;
        tick;

        // Fetch only, ack three cycles after the request rises
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 4'h0);
        tick;
        checkOutput("f1_req", {31'd0, oMemReq}, 32'd1);
        checkOutput("f1_addr", oMemAddr, 32'h100);
        checkOutput("f1_we", {31'd0, oMemWe}, 32'd0);
        checkOutput("f1_ctrl", {28'd0, oMemCtrl}, 32'd0);
        tick;
        tick;
        checkOutput("f1_done_early", {31'd0, oFetchDone}, 32'd0);
        iMemAck   = 1'b1;
        iMemRData = 32'h00500093;
        tick;
        iMemAck   = 1'b0;
        iFetchReq = 1'b0;
        checkOutput("f1_done", {31'd0, oFetchDone}, 32'd1);
        checkOutput("f1_err", {31'd0, oFetchErr}, 32'd0);
        checkOutput("f1_instr", oFetchInstr, 32'h00500093);
        checkOutput("f1_req_low", {31'd0, oMemReq}, 32'd0);
        checkOutput("f1_ddone", {31'd0, oDataDone}, 32'd0);
        tick;
        checkOutput("f1_done_pulse", {31'd0, oFetchDone}, 32'd0);
        expInstr = 32'h00500093;
        expRData = 32'd0;

        // Both requesters held with immediate acks: D,D,D,D,F repeating
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, '0, 4'h5);
        for (int k = 0; k < 10; k++) begin
            isD = ((k % 5) != 4);
            n = 0;
            while (!oMemReq && n < 10) begin
                tick;
                n++;
            end
            checkOutput($sformatf("arb%0d_req", k), {31'd0, oMemReq}, 32'd1);
            checkOutput($sformatf("arb%0d_addr", k), oMemAddr, isD ? 32'h300 : 32'h200);
            iMemAck   = 1'b1;
            iMemRData = 32'hA000 + k;
            tick;
            iMemAck = 1'b0;
            if (isD) begin
                expRData = 32'hA000 + k;
                checkOutput($sformatf("arb%0d_ddone", k), {31'd0, oDataDone}, 32'd1);
                checkOutput($sformatf("arb%0d_fdone", k), {31'd0, oFetchDone}, 32'd0);
                checkOutput($sformatf("arb%0d_rdata", k), oDataRData, expRData);
            end else begin
                expInstr = 32'hA000 + k;
                checkOutput($sformatf("arb%0d_fdone", k), {31'd0, oFetchDone}, 32'd1);
                checkOutput($sformatf("arb%0d_ddone", k), {31'd0, oDataDone}, 32'd0);
                checkOutput($sformatf("arb%0d_instr", k), oFetchInstr, expInstr);
            end
            tick;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick;
        tick;

        // Data store: fields stable through BUSY, load data untouched
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h10000, 32'hDEADBEEF, 4'h2);
        tick;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("st%0d_req", c), {31'd0, oMemReq}, 32'd1);
            checkOutput($sformatf("st%0d_we", c), {31'd0, oMemWe}, 32'd1);
            checkOutput($sformatf("st%0d_addr", c), oMemAddr, 32'h10000);
            checkOutput($sformatf("st%0d_wdata", c), oMemWData, 32'hDEADBEEF);
            checkOutput($sformatf("st%0d_ctrl", c), {28'd0, oMemCtrl}, 32'd2);
            tick;
        end
        iMemAck   = 1'b1;
        iMemRData = 32'h12345678;
        tick;
        iMemAck  = 1'b0;
        iDataReq = 1'b0;
        checkOutput("st_done", {31'd0, oDataDone}, 32'd1);
        checkOutput("st_err", {31'd0, oDataErr}, 32'd0);
        checkOutput("st_rdata", oDataRData, expRData);
        tick;

        // Fetch with no ack: request held exactly TIMEOUT cycles, then error
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 4'h0);
        tick;
        n = 0;
        while (oMemReq && n < 20) begin
            n++;
            tick;
        end
        iFetchReq = 1'b0;
        checkOutput("to_cycles", n, 32'd8);
        checkOutput("to_done", {31'd0, oFetchDone}, 32'd1);
        checkOutput("to_err", {31'd0, oFetchErr}, 32'd1);
        checkOutput("to_instr", oFetchInstr, expInstr);
        tick;
        checkOutput("to_err_pulse", {31'd0, oFetchErr}, 32'd0);

        // Ack on the final allowed cycle still succeeds
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 4'h0);
        tick;
        for (int c = 0; c < 7; c++) tick;
        checkOutput("edge_req", {31'd0, oMemReq}, 32'd1);
        iMemAck   = 1'b1;
        iMemRData = 32'hCAFEF00D;
        tick;
        iMemAck   = 1'b0;
        iFetchReq = 1'b0;
        checkOutput("edge_done", {31'd0, oFetchDone}, 32'd1);
        checkOutput("edge_err", {31'd0, oFetchErr}, 32'd0);
        checkOutput("edge_instr", oFetchInstr, 32'hCAFEF00D);
        tick;

        // Reset in the middle of a data load
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h600, '0, 4'h1);
        tick;
        checkOutput("rb_req", {31'd0, oMemReq}, 32'd1);
        iRst = 1'b1;
        #1;
        checkOutput("rb_memreq", {31'd0, oMemReq}, 32'd0);
        checkOutput("rb_addr", oMemAddr, 32'd0);
        checkOutput("rb_ctrl", {28'd0, oMemCtrl}, 32'd0);
        checkOutput("rb_rdata", oDataRData, 32'd0);
        checkOutput("rb_instr", oFetchInstr, 32'd0);
        iDataReq = 1'b0;
        #1;
        iRst = 1'b0;
        iMemAck   = 1'b1;
        iMemRData = 32'h55555555;
        tick;
        iMemAck = 1'b0;
        checkOutput("rb_stray_ddone", {31'd0, oDataDone}, 32'd0);
        checkOutput("rb_stray_fdone", {31'd0, oFetchDone}, 32'd0);
        checkOutput("rb_stray_req", {31'd0, oMemReq}, 32'd0);
        checkOutput("rb_stray_rdata", oDataRData, 32'd0);
        tick;
        checkOutput("rb_idle_ddone", {31'd0, oDataDone}, 32'd0);
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, '0, '0, 4'h0);
        tick;
        checkOutput("rb_next_req", {31'd0, oMemReq}, 32'd1);
        checkOutput("rb_next_addr", oMemAddr, 32'h700);
        iMemAck   = 1'b1;
        iMemRData = 32'h11112222;
        tick;
        iMemAck   = 1'b0;
        iFetchReq = 1'b0;
        checkOutput("rb_next_done", {31'd0, oFetchDone}, 32'd1);
        checkOutput("rb_next_instr", oFetchInstr, 32'h11112222);
        tick;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
